// File: rtl/simple_pkg.sv
// Shared encodings for the multi-cycle sequencer: phase codes, instruction
// field values, ALU function codes and the branch-condition evaluator.
package simple_pkg;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_P1   = 3'd1;
    localparam logic [2:0] PH_P2   = 3'd2;
    localparam logic [2:0] PH_P3   = 3'd3;
    localparam logic [2:0] PH_P4   = 3'd4;
    localparam logic [2:0] PH_P5   = 3'd5;
    localparam logic [2:0] PH_HALT = 3'd7;

    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ALU = 2'b11;

    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    localparam logic [3:0] OP3_ADD  = 4'b0000;
    localparam logic [3:0] OP3_SUB  = 4'b0001;
    localparam logic [3:0] OP3_AND  = 4'b0010;
    localparam logic [3:0] OP3_OR   = 4'b0011;
    localparam logic [3:0] OP3_XOR  = 4'b0100;
    localparam logic [3:0] OP3_CMP  = 4'b0101;
    localparam logic [3:0] OP3_MOV  = 4'b0110;
    localparam logic [3:0] OP3_RSV0 = 4'b0111;
    localparam logic [3:0] OP3_SLL  = 4'b1000;
    localparam logic [3:0] OP3_SLR  = 4'b1001;
    localparam logic [3:0] OP3_SRL  = 4'b1010;
    localparam logic [3:0] OP3_SRA  = 4'b1011;
    localparam logic [3:0] OP3_IN   = 4'b1100;
    localparam logic [3:0] OP3_OUT  = 4'b1101;
    localparam logic [3:0] OP3_RSV1 = 4'b1110;
    localparam logic [3:0] OP3_HLT  = 4'b1111;

    localparam logic [3:0] ALU_ADD = OP3_ADD;
    localparam logic [3:0] ALU_MOV = OP3_MOV;

    function automatic logic cond_taken(input logic [2:0] cond, input logic s,
                                        input logic z, input logic v);
        logic taken;
        taken = 1'b0;
        case (cond)
            COND_BE:  taken = z;
            COND_BLT: taken = s ^ v;
            COND_BLE: taken = z | (s ^ v);
            COND_BNE: taken = ~z;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/sequencer_decode.sv
// Combinational instruction decode: turns the opcode fields of IR into the
// per-instruction control bits the phase FSM gates by phase.
module sequencer_decode
    import simple_pkg::*;
(
    input  logic [11:0] i_op_field,
    output logic        o_is_ld,
    output logic        o_is_st,
    output logic        o_is_jmp,
    output logic        o_is_bcc,
    output logic        o_is_hlt,
    output logic [2:0]  o_cond,
    output logic        o_wr_reg,
    output logic        o_wr_flag,
    output logic        o_use_p4,
    output logic        o_sel_rb,
    output logic        o_sel_imm,
    output logic [3:0]  o_alu_code
);

    logic [1:0] w_class;
    logic [2:0] w_op2;
    logic [3:0] w_op3;

    assign w_class = i_op_field[11:10];
    assign w_op2   = i_op_field[9:7];
    assign o_cond  = i_op_field[6:4];
    assign w_op3   = i_op_field[3:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_is_ld    = 1'b0;
        o_is_st    = 1'b0;
        o_is_jmp   = 1'b0;
        o_is_bcc   = 1'b0;
        o_is_hlt   = 1'b0;
        o_wr_reg   = 1'b0;
        o_wr_flag  = 1'b0;
        o_use_p4   = 1'b0;
        o_sel_rb   = 1'b0;
        o_sel_imm  = 1'b0;
        o_alu_code = ALU_ADD;
        case (w_class)
            CLS_LD: begin
                o_is_ld  = 1'b1;
                o_wr_reg = 1'b1;
                o_sel_rb = 1'b1;
                o_use_p4 = 1'b1;
            end
            CLS_ST: begin
                o_is_st  = 1'b1;
                o_use_p4 = 1'b1;
            end
            CLS_BR: begin
                case (w_op2)
                    OP2_LI: begin
                        o_wr_reg   = 1'b1;
                        o_sel_rb   = 1'b1;
                        o_sel_imm  = 1'b1;
                        o_alu_code = ALU_MOV;
                    end
                    OP2_B: begin
                        o_is_jmp  = 1'b1;
                        o_sel_imm = 1'b1;
                        o_use_p4  = 1'b1;
                    end
                    OP2_BCC: begin
                        // Only BE/BLT/BLE/BNE exist; the upper four conditions fall through as NOP.
                        if (!o_cond[2]) begin
                            o_is_bcc  = 1'b1;
                            o_sel_imm = 1'b1;
                            o_use_p4  = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: begin
                o_alu_code = w_op3;
                case (w_op3)
                    OP3_HLT:                     o_is_hlt  = 1'b1;
                    OP3_CMP:                     o_wr_flag = 1'b1;
                    OP3_IN:                      o_wr_reg  = 1'b1;
                    OP3_OUT, OP3_RSV0, OP3_RSV1: ;
                    default: begin
                        o_wr_reg  = 1'b1;
                        o_wr_flag = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multi-cycle core: P1..P5 FSM with memory wait
// states, run/stop toggle and HALT, driving all datapath controls.
module multicycle_sequencer
    import simple_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ALU_OP_W = 4,
    parameter bit SKIP_P4  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exec,
    input  logic [DATA_W-1:0]   instr,
    input  logic                S,
    input  logic                Z,
    input  logic                C,
    input  logic                V,
    input  logic                mem_ack,
    output logic                ir_e,
    output logic                ar_e,
    output logic                br_e,
    output logic                dr_e,
    output logic                mdr_e,
    output logic                reg_e,
    output logic                pc_e,
    output logic                flag_e,
    output logic                mem_e,
    output logic                mem_w,
    output logic                m1_s,
    output logic                m2_s,
    output logic                m3_s,
    output logic                m4_s,
    output logic                m5_s,
    output logic                m6_s,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          phase,
    output logic                halted
);

    logic [2:0] r_phase;
    logic [2:0] w_phase_nxt;
    logic       r_stop;
    logic       w_stop_nxt;

    logic       w_is_ld, w_is_st, w_is_jmp, w_is_bcc, w_is_hlt;
    logic [2:0] w_cond;
    logic       w_wr_reg, w_wr_flag, w_use_p4, w_sel_rb, w_sel_imm;
    logic [3:0] w_alu_code;
    logic       w_mem_op;
    logic       w_taken;
    logic       w_running;
    logic       w_unused_ok;

    sequencer_decode u_decode (
        .i_op_field (instr[DATA_W-1:DATA_W-12]),
        .o_is_ld    (w_is_ld),
        .o_is_st    (w_is_st),
        .o_is_jmp   (w_is_jmp),
        .o_is_bcc   (w_is_bcc),
        .o_is_hlt   (w_is_hlt),
        .o_cond     (w_cond),
        .o_wr_reg   (w_wr_reg),
        .o_wr_flag  (w_wr_flag),
        .o_use_p4   (w_use_p4),
        .o_sel_rb   (w_sel_rb),
        .o_sel_imm  (w_sel_imm),
        .o_alu_code (w_alu_code)
    );

    assign w_mem_op    = w_is_ld | w_is_st;
    assign w_taken     = w_is_jmp | (w_is_bcc & cond_taken(w_cond, S, Z, V));
    assign w_running   = (r_phase != PH_IDLE) && (r_phase != PH_HALT);
    assign w_unused_ok = ^{C, instr[DATA_W-13:0]};

    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            PH_IDLE: if (exec) w_phase_nxt = PH_P1;
            PH_P1:   if (mem_ack) w_phase_nxt = PH_P2;
            PH_P2:   w_phase_nxt = PH_P3;
            PH_P3: begin
                if (w_is_hlt)                 w_phase_nxt = PH_HALT;
                else if (w_use_p4 || !SKIP_P4) w_phase_nxt = PH_P4;
                else                          w_phase_nxt = PH_P5;
            end
            PH_P4:   if (!w_mem_op || mem_ack) w_phase_nxt = PH_P5;
            PH_P5:   w_phase_nxt = (r_stop || exec) ? PH_IDLE : PH_P1;
            PH_HALT: w_phase_nxt = PH_HALT;
            default: w_phase_nxt = PH_IDLE;
        endcase
        w_stop_nxt = (w_phase_nxt == PH_IDLE) ? 1'b0 : (r_stop | (exec & w_running));
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so both flops update from pre-edge values.
        if (!rst) begin
            r_phase <= PH_IDLE;
            r_stop  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_stop  <= w_stop_nxt;
        end
    end

    always_comb begin
        ir_e   = 1'b0;
        ar_e   = 1'b0;
        br_e   = 1'b0;
        dr_e   = 1'b0;
        mdr_e  = 1'b0;
        reg_e  = 1'b0;
        pc_e   = 1'b0;
        flag_e = 1'b0;
        mem_e  = 1'b0;
        mem_w  = 1'b0;
        m1_s   = 1'b0;
        m2_s   = 1'b0;
        m3_s   = 1'b0;
        m4_s   = 1'b0;
        m5_s   = 1'b0;
        m6_s   = 1'b0;
        alu_op = '0;
        case (r_phase)
            PH_P1: begin
                mem_e = 1'b1;
                if (mem_ack) begin
                    ir_e = 1'b1;
                    pc_e = 1'b1;
                    m1_s = 1'b1;
                end
            end
            PH_P2: begin
                ar_e = 1'b1;
                br_e = 1'b1;
                m2_s = w_sel_imm;
                m3_s = w_is_jmp | w_is_bcc;
            end
            PH_P3: begin
                dr_e   = 1'b1;
                flag_e = w_wr_flag;
                alu_op = ALU_OP_W'(w_alu_code);
            end
            PH_P4: begin
                // Stores address memory through DR exactly as loads do.
                if (w_mem_op) begin
                    mem_e = 1'b1;
                    m6_s  = 1'b1;
                    mem_w = w_is_st;
                    mdr_e = w_is_ld & mem_ack;
                end
                pc_e = w_taken;
            end
            PH_P5: begin
                reg_e = w_wr_reg;
                m4_s  = w_is_ld;
                m5_s  = w_sel_rb;
            end
            default: ;
        endcase
    end

    assign phase  = r_phase;
    assign halted = (r_phase == PH_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle traces of phase, alu_op and
// the 16 control bits compared against hand-computed vectors.
module tb_multicycle_sequencer;

    localparam logic [15:0] K_IR   = 16'h8000;
    localparam logic [15:0] K_AR   = 16'h4000;
    localparam logic [15:0] K_BR   = 16'h2000;
    localparam logic [15:0] K_DR   = 16'h1000;
    localparam logic [15:0] K_MDR  = 16'h0800;
    localparam logic [15:0] K_REG  = 16'h0400;
    localparam logic [15:0] K_PC   = 16'h0200;
    localparam logic [15:0] K_FLAG = 16'h0100;
    localparam logic [15:0] K_MEM  = 16'h0080;
    localparam logic [15:0] K_MW   = 16'h0040;
    localparam logic [15:0] K_M1   = 16'h0020;
    localparam logic [15:0] K_M2   = 16'h0010;
    localparam logic [15:0] K_M3   = 16'h0008;
    localparam logic [15:0] K_M4   = 16'h0004;
    localparam logic [15:0] K_M5   = 16'h0002;
    localparam logic [15:0] K_M6   = 16'h0001;
    localparam logic [15:0] FETCH  = K_MEM | K_IR | K_PC | K_M1;

    logic        clk = 1'b0;
    logic        rst, exec, S, Z, C, V, mem_ack;
    logic [15:0] instr;

    wire [15:0] ctl, ctl_n;
    wire [3:0]  alu_op, alu_op_n;
    wire [2:0]  phase, phase_n;
    wire        halted, halted_n;
    wire [22:0] obs   = {phase, alu_op, ctl};
    wire [22:0] obs_n = {phase_n, alu_op_n, ctl_n};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.DATA_W(16), .ALU_OP_W(4), .SKIP_P4(1'b1)) dut (
        .clk(clk), .rst(rst), .exec(exec), .instr(instr),
        .S(S), .Z(Z), .C(C), .V(V), .mem_ack(mem_ack),
        .ir_e(ctl[15]), .ar_e(ctl[14]), .br_e(ctl[13]), .dr_e(ctl[12]), .mdr_e(ctl[11]),
        .reg_e(ctl[10]), .pc_e(ctl[9]), .flag_e(ctl[8]), .mem_e(ctl[7]), .mem_w(ctl[6]),
        .m1_s(ctl[5]), .m2_s(ctl[4]), .m3_s(ctl[3]), .m4_s(ctl[2]), .m5_s(ctl[1]), .m6_s(ctl[0]),
        .alu_op(alu_op), .phase(phase), .halted(halted)
    );

    multicycle_sequencer #(.DATA_W(16), .ALU_OP_W(4), .SKIP_P4(1'b0)) dut_noskip (
        .clk(clk), .rst(rst), .exec(exec), .instr(instr),
        .S(S), .Z(Z), .C(C), .V(V), .mem_ack(mem_ack),
        .ir_e(ctl_n[15]), .ar_e(ctl_n[14]), .br_e(ctl_n[13]), .dr_e(ctl_n[12]), .mdr_e(ctl_n[11]),
        .reg_e(ctl_n[10]), .pc_e(ctl_n[9]), .flag_e(ctl_n[8]), .mem_e(ctl_n[7]), .mem_w(ctl_n[6]),
        .m1_s(ctl_n[5]), .m2_s(ctl_n[4]), .m3_s(ctl_n[3]), .m4_s(ctl_n[2]), .m5_s(ctl_n[1]), .m6_s(ctl_n[0]),
        .alu_op(alu_op_n), .phase(phase_n), .halted(halted_n)
    );

    function automatic logic [22:0] ev(input logic [2:0] ph, input logic [3:0] alu, input logic [15:0] c);
        return {ph, alu, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; exec = 1'b0; mem_ack = 1'b0; instr = 16'h0000;
        S = 1'b0; Z = 1'b0; C = 1'b0; V = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; exec = 1'b1; mem_ack = 1'b1; instr = 16'hC800;
        S = 1'b0; Z = 1'b0; C = 1'b0; V = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (obs !== 23'h0) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs, 23'h0); end
        n_cmp++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++;
        if (obs_n !== 23'h0) begin n_err++; $display("FAIL reset_outputs_noskip: got %h want %h", obs_n, 23'h0); end
    endtask

    task automatic test_add();
        logic [22:0] e [6];
        do_reset();
        instr = 16'hC800;
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR), ev(3,0,K_DR|K_FLAG), ev(5,0,K_REG), ev(1,0,FETCH)};
        for (int i = 0; i < 6; i++) begin
            exec = (i == 0); mem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL add[%0d]: got %h want %h", i, obs, e[i]); end
            tick();
        end
    endtask

    task automatic test_ld();
        logic [22:0] e [11];
        bit          ack [11];
        do_reset();
        instr = 16'h0A05;
        ack = '{1,0,0,1,1,1,0,0,1,0,0};
        e = '{ev(0,0,0), ev(1,0,K_MEM), ev(1,0,K_MEM), ev(1,0,FETCH), ev(2,0,K_AR|K_BR),
              ev(3,0,K_DR), ev(4,0,K_MEM|K_M6), ev(4,0,K_MEM|K_M6), ev(4,0,K_MEM|K_M6|K_MDR),
              ev(5,0,K_REG|K_M4|K_M5), ev(1,0,K_MEM)};
        for (int i = 0; i < 11; i++) begin
            exec = (i == 0); mem_ack = ack[i];
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL ld[%0d]: got %h want %h", i, obs, e[i]); end
            tick();
        end
    endtask

    task automatic test_st();
        logic [22:0] e [8];
        bit          ack [8];
        do_reset();
        instr = 16'h4A05;
        ack = '{0,1,0,0,0,1,0,1};
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR), ev(3,0,K_DR),
              ev(4,0,K_MEM|K_MW|K_M6), ev(4,0,K_MEM|K_MW|K_M6), ev(5,0,0), ev(1,0,FETCH)};
        for (int i = 0; i < 8; i++) begin
            exec = (i == 0); mem_ack = ack[i];
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL st[%0d]: got %h want %h", i, obs, e[i]); end
            tick();
        end
    endtask

    task automatic test_branch(input logic z_in);
        logic [22:0] e [7];
        do_reset();
        instr = 16'hB802;
        Z = z_in;
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR|K_M2|K_M3), ev(3,0,K_DR),
              ev(4,0,z_in ? K_PC : 16'h0000), ev(5,0,0), ev(1,0,FETCH)};
        for (int i = 0; i < 7; i++) begin
            exec = (i == 0); mem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL branch_z%0b[%0d]: got %h want %h", z_in, i, obs, e[i]); end
            tick();
        end
    endtask

    task automatic test_hlt();
        logic [22:0] e [7];
        do_reset();
        instr = 16'hC0F0;
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR), ev(3,4'hF,K_DR),
              ev(7,0,0), ev(7,0,0), ev(7,0,0)};
        for (int i = 0; i < 7; i++) begin
            exec = (i == 0) || (i == 5); mem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL hlt[%0d]: got %h want %h", i, obs, e[i]); end
            n_cmp++;
            if (halted !== (i >= 4)) begin n_err++; $display("FAIL hlt_halted[%0d]: got %b want %b", i, halted, (i >= 4)); end
            tick();
        end
        rst = 1'b0;
        #2;
        n_cmp++;
        if (obs !== 23'h0) begin n_err++; $display("FAIL hlt_async_reset: got %h want %h", obs, 23'h0); end
        n_cmp++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL hlt_reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_stop(input int ex_idx);
        logic [22:0] e [7];
        do_reset();
        instr = 16'hC800;
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR), ev(3,0,K_DR|K_FLAG),
              ev(5,0,K_REG), ev(0,0,0), ev(0,0,0)};
        for (int i = 0; i < 7; i++) begin
            exec = (i == 0) || (i == ex_idx); mem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL stop_at%0d[%0d]: got %h want %h", ex_idx, i, obs, e[i]); end
            tick();
        end
    endtask

    task automatic test_cmp_nop();
        logic [22:0] e [5];
        for (int k = 0; k < 2; k++) begin
            do_reset();
            instr = (k == 0) ? 16'hC050 : 16'hC070;
            e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR),
                  (k == 0) ? ev(3,4'h5,K_DR|K_FLAG) : ev(3,4'h7,K_DR), ev(5,0,0)};
            for (int i = 0; i < 5; i++) begin
                exec = (i == 0); mem_ack = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (obs !== e[i]) begin n_err++; $display("FAIL cmp_nop%0d[%0d]: got %h want %h", k, i, obs, e[i]); end
                tick();
            end
        end
    endtask

    task automatic test_reset_midwait();
        logic [22:0] e [5];
        bit          ack [5];
        do_reset();
        instr = 16'h0A05;
        ack = '{0,1,0,0,0};
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR), ev(3,0,K_DR), ev(4,0,K_MEM|K_M6)};
        for (int i = 0; i < 5; i++) begin
            exec = (i == 0); mem_ack = ack[i];
            @(negedge clk);
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL midwait[%0d]: got %h want %h", i, obs, e[i]); end
            tick();
        end
        mem_ack = 1'b1;
        rst = 1'b0;
        #2;
        n_cmp++;
        if (obs !== 23'h0) begin n_err++; $display("FAIL midwait_abort: got %h want %h", obs, 23'h0); end
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (obs !== 23'h0) begin n_err++; $display("FAIL midwait_idle: got %h want %h", obs, 23'h0); end
        tick();
    endtask

    task automatic test_no_skip();
        logic [22:0] e [7];
        do_reset();
        instr = 16'hC800;
        e = '{ev(0,0,0), ev(1,0,FETCH), ev(2,0,K_AR|K_BR), ev(3,0,K_DR|K_FLAG),
              ev(4,0,0), ev(5,0,K_REG), ev(1,0,FETCH)};
        for (int i = 0; i < 7; i++) begin
            exec = (i == 0); mem_ack = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (obs_n !== e[i]) begin n_err++; $display("FAIL no_skip[%0d]: got %h want %h", i, obs_n, e[i]); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld();
        test_st();
        test_branch(1'b1);
        test_branch(1'b0);
        test_hlt();
        test_stop(2);
        test_stop(1);
        test_cmp_nop();
        test_reset_midwait();
        test_no_skip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
